// File: rtl/ikaopll_pkg.sv
// Shared constants and types for the OPLL DAC sequencer: slot count, slot masks,
// volume and cycle-index types.
package ikaopll_pkg;

  localparam int CYCLE_NUM = 18;

  typedef logic signed [4:0] vol_t;
  typedef logic [4:0]        cyc_t;

  localparam cyc_t CYC_LAST = cyc_t'(CYCLE_NUM - 1);

  // Melody mode has no rhythm slots; rhythm mode hands cycles 0..4 to RO.
  localparam logic [CYCLE_NUM-1:0] MO_MASK_FM  = 18'h3_232B;
  localparam logic [CYCLE_NUM-1:0] MO_MASK_RHY = 18'h3_2320;
  localparam logic [CYCLE_NUM-1:0] RO_MASK_RHY = 18'h0_001F;

  localparam vol_t VOL_RESET = 5'sd1;

  function automatic cyc_t cyc_next(input cyc_t c);
    return (c == CYC_LAST) ? '0 : c + 5'd1;
  endfunction

endpackage

// File: rtl/ikaopll_vol_ramp.sv
// One accumulation-DAC volume channel: target register plus a current value that
// walks one LSB per step toward the (mute-aware) target.
module ikaopll_vol_ramp
  import ikaopll_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic wr_i,
  input  vol_t data_i,
  input  logic step_i,
  input  logic mute_i,
  output vol_t vol_o,
  output logic busy_o,
  output logic zero_o
);

  vol_t target_q, target_d;
  vol_t cur_q, cur_d;
  vol_t eff_target;

  assign eff_target = mute_i ? vol_t'(0) : target_q;

  // The step compares against the pre-write target, so a same-edge write only
  // influences the following frame.
  always_comb begin
    target_d = wr_i ? data_i : target_q;
    cur_d    = cur_q;
    if (step_i) begin
      if (cur_q < eff_target)      cur_d = cur_q + 5'sd1;
      else if (cur_q > eff_target) cur_d = cur_q - 5'sd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      target_q <= VOL_RESET;
      cur_q    <= VOL_RESET;
    end else begin
      target_q <= target_d;
      cur_q    <= cur_d;
    end
  end

  assign vol_o  = cur_q;
  assign busy_o = (cur_q != eff_target);
  assign zero_o = (cur_q == vol_t'(0));

endmodule

// File: rtl/ikaopll_dac_sequencer.sv
// OPLL DAC timing/config controller: 18-slot counter, MO/RO slot decode with
// frame-aligned rhythm mode, and the two click-free volume ramps.
module ikaopll_dac_sequencer
  import ikaopll_pkg::*;
(
  input  logic       i_EMUCLK,
  input  logic       i_RST,
  input  logic       i_phi1_NCEN_n,
  input  logic       i_RHYTHM_EN_REQ,
  input  logic       i_MUTE,
  input  logic       i_VOL_WR,
  input  logic       i_VOL_SEL,
  input  logic [4:0] i_VOL_DATA,
  output logic       o_CYCLE_00,
  output logic       o_MO_CTRL,
  output logic       o_RO_CTRL,
  output logic       o_DAC_EN,
  output logic       o_INHIBIT_FDBK,
  output logic       o_RHYTHM_EN,
  output logic [4:0] o_ACC_SIGNED_MOVOL,
  output logic [4:0] o_ACC_SIGNED_ROVOL,
  output logic       o_VOL_BUSY,
  output logic       o_MUTED
);

  logic tick, enter0;
  cyc_t cnt_q, cnt_d;
  logic rhythm_q, rhythm_d;
  logic mo_d, ro_d;
  logic cycle00_q, mo_q, ro_q, dac_en_q, inhibit_q;

  assign tick     = ~i_phi1_NCEN_n;
  assign enter0   = tick && (cnt_q == CYC_LAST);
  assign cnt_d    = cyc_next(cnt_q);
  assign rhythm_d = enter0 ? i_RHYTHM_EN_REQ : rhythm_q;

  // Decode looks at the slot being entered, using the mode that slot's frame will run in.
  assign mo_d = rhythm_d ? MO_MASK_RHY[cnt_d] : MO_MASK_FM[cnt_d];
  assign ro_d = RO_MASK_RHY[cnt_d] & rhythm_d;

  always_ff @(posedge i_EMUCLK or posedge i_RST) begin
    if (i_RST) begin
      cnt_q     <= CYC_LAST;
      rhythm_q  <= 1'b0;
      cycle00_q <= 1'b0;
      mo_q      <= 1'b0;
      ro_q      <= 1'b0;
      dac_en_q  <= 1'b0;
      inhibit_q <= 1'b1;
    end else if (tick) begin
      cnt_q     <= cnt_d;
      rhythm_q  <= rhythm_d;
      cycle00_q <= (cnt_d == '0);
      mo_q      <= mo_d;
      ro_q      <= ro_d;
      dac_en_q  <= mo_q | ro_q;
      inhibit_q <= ~(mo_d | ro_d);
    end
  end

  vol_t mo_vol, ro_vol;
  logic mo_busy, ro_busy, mo_zero, ro_zero;

  ikaopll_vol_ramp u_mo_ramp (
    .clk_i  (i_EMUCLK),
    .rst_i  (i_RST),
    .wr_i   (i_VOL_WR & ~i_VOL_SEL),
    .data_i (vol_t'(i_VOL_DATA)),
    .step_i (enter0),
    .mute_i (i_MUTE),
    .vol_o  (mo_vol),
    .busy_o (mo_busy),
    .zero_o (mo_zero)
  );

  ikaopll_vol_ramp u_ro_ramp (
    .clk_i  (i_EMUCLK),
    .rst_i  (i_RST),
    .wr_i   (i_VOL_WR & i_VOL_SEL),
    .data_i (vol_t'(i_VOL_DATA)),
    .step_i (enter0),
    .mute_i (i_MUTE),
    .vol_o  (ro_vol),
    .busy_o (ro_busy),
    .zero_o (ro_zero)
  );

  assign o_CYCLE_00         = cycle00_q;
  assign o_MO_CTRL          = mo_q;
  assign o_RO_CTRL          = ro_q;
  assign o_DAC_EN           = dac_en_q;
  assign o_INHIBIT_FDBK     = inhibit_q;
  assign o_RHYTHM_EN        = rhythm_q;
  assign o_ACC_SIGNED_MOVOL = mo_vol;
  assign o_ACC_SIGNED_ROVOL = ro_vol;
  assign o_VOL_BUSY         = mo_busy | ro_busy;
  assign o_MUTED            = i_MUTE & mo_zero & ro_zero;

endmodule

// File: tb/tb_ikaopll_dac_sequencer.sv
// Randomised + directed bench for the DAC sequencer against a tick/frame-level model.
module tb_ikaopll_dac_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ncen = 1'b1;
  logic       req = 1'b0;
  logic       mute = 1'b0;
  logic       wr = 1'b0;
  logic       sel = 1'b0;
  logic [4:0] data = 5'd0;

  logic       cycle00, mo, ro, dac_en, inhibit, rhy_en, busy, muted;
  logic [4:0] movol, rovol;

  ikaopll_dac_sequencer dut (
    .i_EMUCLK           (clk),
    .i_RST              (rst),
    .i_phi1_NCEN_n      (ncen),
    .i_RHYTHM_EN_REQ    (req),
    .i_MUTE             (mute),
    .i_VOL_WR           (wr),
    .i_VOL_SEL          (sel),
    .i_VOL_DATA         (data),
    .o_CYCLE_00         (cycle00),
    .o_MO_CTRL          (mo),
    .o_RO_CTRL          (ro),
    .o_DAC_EN           (dac_en),
    .o_INHIBIT_FDBK     (inhibit),
    .o_RHYTHM_EN        (rhy_en),
    .o_ACC_SIGNED_MOVOL (movol),
    .o_ACC_SIGNED_ROVOL (rovol),
    .o_VOL_BUSY         (busy),
    .o_MUTED            (muted)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int clk_count = 0;
  bit ncen_random = 0;

  // Reference model: k = ticks since reset, slot = (k-1) mod 18.
  int k;
  int m_mode;
  int m_tgt[2];
  int m_cur[2];
  bit m_mo, m_ro, m_c0, m_inh, m_dac;
  bit m_frame_start;
  bit fm_slot[18];
  bit rhy_slot[18];
  int fm_list[9]  = '{0, 1, 3, 5, 8, 9, 13, 16, 17};
  int rhy_list[6] = '{5, 8, 9, 13, 16, 17};

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int step_toward(input int cur, input int tgt);
    if (cur < tgt) return cur + 1;
    if (cur > tgt) return cur - 1;
    return cur;
  endfunction

  task automatic model_reset();
    k = 0; m_mode = 0;
    m_tgt[0] = 1; m_tgt[1] = 1; m_cur[0] = 1; m_cur[1] = 1;
    m_mo = 0; m_ro = 0; m_c0 = 0; m_inh = 1; m_dac = 0;
    m_frame_start = 0;
  endtask

  task automatic model_edge();
    int slot;
    m_frame_start = 0;
    if (!ncen) begin
      k++;
      slot = (k - 1) % 18;
      m_dac = m_mo | m_ro;
      if (slot == 0) begin
        m_frame_start = 1;
        m_mode = req;
        for (int v = 0; v < 2; v++)
          m_cur[v] = step_toward(m_cur[v], mute ? 0 : m_tgt[v]);
      end
      m_mo  = m_mode ? rhy_slot[slot] : fm_slot[slot];
      m_ro  = (m_mode != 0) && (slot <= 4);
      m_c0  = (slot == 0);
      m_inh = !(m_mo || m_ro);
    end
    if (wr) m_tgt[sel] = $signed(data);
  endtask

  task automatic check_all();
    int eff0, eff1;
    eff0 = mute ? 0 : m_tgt[0];
    eff1 = mute ? 0 : m_tgt[1];
    check_eq("cycle00", cycle00, m_c0);
    check_eq("mo_ctrl", mo, m_mo);
    check_eq("ro_ctrl", ro, m_ro);
    check_eq("mo_and_ro", mo & ro, 0);
    check_eq("dac_en", dac_en, m_dac);
    check_eq("inhibit", inhibit, m_inh);
    check_eq("rhythm_en", rhy_en, m_mode);
    check_eq("movol", $signed(movol), m_cur[0]);
    check_eq("rovol", $signed(rovol), m_cur[1]);
    check_eq("vol_busy", busy, (m_cur[0] != eff0) || (m_cur[1] != eff1));
    check_eq("muted", muted, mute && m_cur[0] == 0 && m_cur[1] == 0);
  endtask

  task automatic run_clk();
    if (ncen_random) ncen = 1'($urandom_range(0, 1));
    else             ncen = ((clk_count / 2) % 2 == 0) ? 1'b0 : 1'b1;
    @(posedge clk);
    clk_count++;
    #1;
    if (rst) model_reset();
    else     model_edge();
    check_all();
  endtask

  task automatic do_write(input bit s, input int value);
    sel = s; data = 5'(value); wr = 1'b1;
    $display("write %s target=%0d (t=%0t)", s ? "RO" : "MO", value, $time);
    run_clk();
    wr = 1'b0;
  endtask

  task automatic wait_slot(input int slot);
    bit found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      run_clk();
      if (k > 0 && (k - 1) % 18 == slot) found = 1;
    end
    check_eq("wait_slot_reached", found, 1);
  endtask

  initial begin
    for (int i = 0; i < 18; i++) begin fm_slot[i] = 0; rhy_slot[i] = 0; end
    foreach (fm_list[i])  fm_slot[fm_list[i]] = 1;
    foreach (rhy_list[i]) rhy_slot[rhy_list[i]] = 1;
    model_reset();

    // Reset state, then melody mode.
    repeat (3) run_clk();
    rst = 1'b0;
    $display("phase: melody mode");
    repeat (36 * 3) run_clk();

    // Rhythm request mid-frame must wait for the next cycle 0.
    $display("phase: rhythm request at slot 7");
    wait_slot(7);
    req = 1'b1;
    repeat (36 * 2) run_clk();

    // MO ramp +1 -> +15 takes exactly 14 frames.
    begin
      int frames = 0;
      bit hit = 0;
      do_write(0, 15);
      for (int i = 0; i < 36 * 20 && !hit; i++) begin
        run_clk();
        if (m_frame_start) frames++;
        if ($signed(movol) == 15) hit = 1;
      end
      check_eq("mo_ramp_done", hit, 1);
      check_eq("mo_ramp_frames", frames, 14);
    end

    // RO down, reversed mid-ramp, then to -16 for the mute test.
    do_write(0, -3);
    do_write(1, -16);
    repeat (36 * 5) run_clk();
    do_write(1, 0);
    do_write(0, 15);
    repeat (36 * 8) run_clk();
    do_write(1, -16);
    repeat (36 * 20) run_clk();
    check_eq("pre_mute_movol", $signed(movol), 15);
    check_eq("pre_mute_rovol", $signed(rovol), -16);

    // Mute needs 16 frames for RO to climb from -16.
    begin
      int frames = 0;
      bit hit = 0;
      mute = 1'b1;
      $display("phase: mute asserted");
      for (int i = 0; i < 36 * 20 && !hit; i++) begin
        run_clk();
        if (m_frame_start) frames++;
        if (muted) hit = 1;
      end
      check_eq("mute_done", hit, 1);
      check_eq("mute_frames", frames, 16);
    end
    mute = 1'b0;
    $display("phase: mute released");
    repeat (36 * 18) run_clk();
    check_eq("unmute_movol", $signed(movol), 15);
    check_eq("unmute_rovol", $signed(rovol), -16);

    // Random traffic.
    $display("phase: random");
    ncen_random = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) req = ~req;
      if ($urandom_range(0, 399) == 0) mute = ~mute;
      if ($urandom_range(0, 39) == 0) do_write(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)) - 16);
      else run_clk();
    end
    mute = 1'b0;

    // Asynchronous reset in the middle of a ramp.
    do_write(0, -12);
    repeat (40) run_clk();
    #2 rst = 1'b1;
    #1;
    $display("phase: async reset mid-ramp");
    check_eq("arst_cycle00", cycle00, 0);
    check_eq("arst_mo", mo, 0);
    check_eq("arst_ro", ro, 0);
    check_eq("arst_dac_en", dac_en, 0);
    check_eq("arst_inhibit", inhibit, 1);
    check_eq("arst_rhythm", rhy_en, 0);
    check_eq("arst_movol", $signed(movol), 1);
    check_eq("arst_rovol", $signed(rovol), 1);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_muted", muted, 0);
    model_reset();
    repeat (2) run_clk();
    rst = 1'b0;
    ncen_random = 0;
    repeat (36 * 2) run_clk();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ikaopll_dac_sequencer.md
Name: ikaopll_dac_sequencer

Overview:
- Timing and configuration controller for the OPLL DAC stage.
- Runs an 18-cycle slot counter on the phi1 negative-edge enable.
- Per cycle, decodes which slot feeds the DAC: melody (MO), rhythm (RO) or none. Drives the DAC's DAC_EN, CYCLE_00, MO_CTRL, RO_CTRL, INHIBIT_FDBK and RHYTHM_EN inputs.
- Owns the accumulation-DAC volume registers. Volume changes and mute ramp one LSB per sample frame to avoid clicks.

Parameters:
- CYCLE_NUM, 18, slots per sample frame; counter wraps CYCLE_NUM-1 -> 0.
- MO_MASK_FM, 18'h3_232B, melody-mode MO cycles: bits 0,1,3,5,8,9,13,16,17.
- MO_MASK_RHY, 18'h3_2320, rhythm-mode MO cycles: bits 5,8,9,13,16,17.
- RO_MASK_RHY, 18'h0_001F, rhythm-mode RO cycles: bits 0..4.

Ports:
- i_EMUCLK  in  1  master clock; all flops on posedge.
- i_RST  in  1  reset; asynchronous assert, active-high.
- i_phi1_NCEN_n  in  1  clock enable, active-low. State advances only when low.
- i_RHYTHM_EN_REQ  in  1  requested rhythm mode (register-file bit).
- i_MUTE  in  1  level; ramp both volumes to 0 while high.
- i_VOL_WR  in  1  one-emuclk write strobe.
- i_VOL_SEL  in  1  0 = MO volume target, 1 = RO volume target.
- i_VOL_DATA  in  5  signed target volume.
- o_CYCLE_00  out  1  high during cycle 0.
- o_MO_CTRL  out  1  current cycle is a melody slot.
- o_RO_CTRL  out  1  current cycle is a rhythm slot.
- o_DAC_EN  out  1  impulse window; MO_CTRL|RO_CTRL delayed one enabled phase.
- o_INHIBIT_FDBK  out  1  current cycle is neither MO nor RO.
- o_RHYTHM_EN  out  1  frame-aligned rhythm mode.
- o_ACC_SIGNED_MOVOL  out  5  current signed MO volume.
- o_ACC_SIGNED_ROVOL  out  5  current signed RO volume.
- o_VOL_BUSY  out  1  either current volume differs from its effective target.
- o_MUTED  out  1  i_MUTE high and both current volumes are 0.

Behaviour:
- Reset values:
  - cnt = CYCLE_NUM-1, so the first enabled phase enters cycle 0.
  - All control outputs 0, except o_INHIBIT_FDBK = 1.
  - o_RHYTHM_EN = 0.
  - Targets and current volumes = +1 (5'sd1).
  - o_VOL_BUSY = 0, o_MUTED = 0.
- Tick: one emuclk with i_phi1_NCEN_n low. Nothing changes on non-tick clocks except target writes.
- Counter: cnt <= (cnt == CYCLE_NUM-1) ? 0 : cnt+1 on each tick.
- Rhythm latch:
  - o_RHYTHM_EN <= i_RHYTHM_EN_REQ only on the tick that enters cycle 0.
  - A mid-frame request change never splits a frame.
- Decode: registered on the same tick as cnt, from the next cnt value and the latched mode.
  - o_MO_CTRL = mask_MO[next]; o_RO_CTRL = RO_RHY[next] & mode.
  - o_INHIBIT_FDBK = ~(o_MO_CTRL|o_RO_CTRL).
  - o_CYCLE_00 = (next == 0).
- o_DAC_EN: registered copy of (o_MO_CTRL|o_RO_CTRL), i.e. one tick later.
- MO and RO are never both high; masks are disjoint by construction.
- Volume write:
  - On i_VOL_WR, target[i_VOL_SEL] <= i_VOL_DATA. Writes take effect on any emuclk, independent of tick.
  - Full range -16..+15 is accepted.
  - A write during an active ramp retargets immediately; the ramp continues from the current value.
- Effective target = i_MUTE ? 0 : target.
- Ramp:
  - Runs on the tick entering cycle 0, once per frame.
  - Each current volume steps ±1 toward its effective target; MO and RO step independently.
  - Equal values hold. No overshoot; saturation is implicit.
- Mute deassert: ramps back to the stored targets. Targets are not lost.
- o_VOL_BUSY and o_MUTED are combinational from registers.
- Reset mid-ramp or mid-frame: all state returns to reset values immediately (async).
- Simultaneous write and ramp tick on the same emuclk: the write updates the target, and the step uses the old target.

Decomposition:
- Shared package ikaopll_pkg:
  - CYCLE_NUM;
  - mask constants;
  - volume type (signed 5-bit);
  - cycle index type (5-bit).
- One sub-module, ikaopll_vol_ramp, instantiated twice (MO, RO): target register, write port, step logic, busy flag.

Test Plan:
- Reset release, i_phi1_NCEN_n toggling every 2 emuclk, rhythm 0:
  - o_CYCLE_00 pulses every 18 ticks.
  - o_MO_CTRL high on cycles 0,1,3,5,8,9,13,16,17.
  - o_RO_CTRL never high.
- Assert i_RHYTHM_EN_REQ at cycle 7:
  - o_RHYTHM_EN rises only on the next cycle 0.
  - RO high on cycles 0..4; MO only on 5,8,9,13,16,17.
  - o_INHIBIT_FDBK high on the remaining 7 cycles.
- Each cycle: o_DAC_EN equals the previous tick's MO|RO; never MO&RO.
- Write MO = +15 from +1:
  - o_VOL_BUSY high; MOVOL reaches 15 after exactly 14 frames, then BUSY drops.
- Write RO = -16 while MO ramping:
  - RO steps down independently; MO is unaffected.
  - Mid-ramp rewrite RO = 0 reverses the direction next frame.
- Mute with MO = 15, RO = -16:
  - o_MUTED asserts after 16 frames.
  - Deassert -> volumes return to 15/-16.
  - Assert i_RST mid-ramp -> immediate reset values.
